// File: rtl/add_full_bist.sv
// add_full_bist: BIST controller for a combinational full adder, 8-bit MISR signature.
// Optional per-pattern compare against an internal golden adder is enabled by ADD_FULL_BIST_PATCHK_EN.
`default_nettype none

module add_full_bist #(
  parameter int         NPAT       = 8,
  parameter logic [7:0] GOLDEN_SIG = 8'hC5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       cin,
  input  logic       s,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] fail_cnt,
  output logic [3:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] POLY = 8'h1D;
  localparam logic [3:0] LAST = 4'(NPAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] stim;
  logic [7:0] sig_next;

  assign sig_next = {signature[6:0], 1'b0} ^ (signature[7] ? POLY : 8'h00) ^ {6'b0, s, cout};

  assign {x, y, cin} = stim;
  assign pass        = (signature == GOLDEN_SIG);

  // stim is kept equal to cnt[2:0] throughout RUN and forced to zero elsewhere
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      stim      <= 3'd0;
      signature <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= 4'd0;
            stim      <= 3'd0;
            signature <= 8'h00;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          signature <= sig_next;
          cnt       <= cnt + 4'd1;
          if (cnt == LAST) begin
            state <= DONE;
            stim  <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            stim <= cnt[2:0] + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          stim  <= 3'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADD_FULL_BIST_PATCHK_EN
  logic exp_s;
  logic exp_cout;
  logic mism;

  assign exp_s    = ^stim;
  assign exp_cout = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
  assign mism     = (s != exp_s) || (cout != exp_cout);

  // fail_cnt is still zero until the first mismatch, so it doubles as the "no failure yet" flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt   <= 5'd0;
      first_fail <= 4'd0;
    end else if (state != RUN) begin
      if (start) begin
        fail_cnt   <= 5'd0;
        first_fail <= 4'd0;
      end
    end else if (mism) begin
      if (fail_cnt == 5'd0) begin
        first_fail <= cnt;
      end
      if (fail_cnt != 5'd31) begin
        fail_cnt <= fail_cnt + 5'd1;
      end
    end
  end
`else
  assign fail_cnt   = 5'd0;
  assign first_fail = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_full_bist.sv
// Directed self-checking bench for add_full_bist (NPAT=8 instance plus an NPAT=16 instance).
`default_nettype none

module tb_add_full_bist;

`ifdef ADD_FULL_BIST_PATCHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start16;
  logic       x8, y8, c8, s8, co8, busy8, done8, pass8;
  logic [7:0] sig8;
  logic [4:0] fc8;
  logic [3:0] ff8;
  logic       x16, y16, c16, s16, co16, busy16, done16, pass16;
  logic [7:0] sig16;
  logic [4:0] fc16;
  logic [3:0] ff16;
  int         fault;
  int         compared   = 0;
  int         mismatched = 0;
  int         cyc;

  always #5 clk = ~clk;

  add_full_bist #(.NPAT(8), .GOLDEN_SIG(8'hC5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .x(x8), .y(y8), .cin(c8), .s(s8), .cout(co8),
    .busy(busy8), .done(done8), .pass(pass8),
    .signature(sig8), .fail_cnt(fc8), .first_fail(ff8)
  );

  add_full_bist #(.NPAT(16), .GOLDEN_SIG(8'h99)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .x(x16), .y(y16), .cin(c16), .s(s16), .cout(co16),
    .busy(busy16), .done(done16), .pass(pass16),
    .signature(sig16), .fail_cnt(fc16), .first_fail(ff16)
  );

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] sg, input logic si, input logic ci);
    return {sg[6:0], 1'b0} ^ (sg[7] ? 8'h1D : 8'h00) ^ {6'b0, si, ci};
  endfunction

  // Adder under test: 0 good, 1 cout stuck-at-0, 2 s stuck-at-1 on pattern 0 only
  always_comb begin
    s8  = x8 ^ y8 ^ c8;
    co8 = maj(x8, y8, c8);
    if (fault == 1) co8 = 1'b0;
    if (fault == 2 && busy8 && {x8, y8, c8} == 3'b000) s8 = 1'b1;
  end

  assign s16  = x16 ^ y16 ^ c16;
  assign co16 = maj(x16, y16, c16);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic pulse8();
    @(negedge clk) start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
  endtask

  // Counts edges after the start edge until done, bounded at 40
  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    logic [7:0] model;
    rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; fault = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", sig8, 8'h00);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_stim", {x8, y8, c8}, 3'b000);
    chk("rst_fail_cnt", fc8, 5'd0);
    chk("rst_first_fail", ff8, 4'd0);
    @(negedge clk) rst_n = 1'b1;

    // Good adder
    pulse8();
    chk("good_busy_start", busy8, 1'b1);
    chk("good_sig_start", sig8, 8'h00);
    wait_done8(cyc);
    chk("good_run_len", cyc, 8);
    chk("good_sig", sig8, 8'hC5);
    chk("good_pass", pass8, 1'b1);
    chk("good_fail_cnt", fc8, 5'd0);
    chk("good_busy_end", busy8, 1'b0);
    chk("good_stim_end", {x8, y8, c8}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", done8, 1'b1);
    chk("done_sig_hold", sig8, 8'hC5);

    // cout stuck-at-0
    fault = 1;
    pulse8();
    wait_done8(cyc);
    chk("sa0_run_len", cyc, 8);
    chk("sa0_sig", sig8, 8'hD2);
    chk("sa0_pass", pass8, 1'b0);
    chk("sa0_fail_cnt", fc8, CHK ? 5'd4 : 5'd0);
    chk("sa0_first_fail", ff8, CHK ? 4'd3 : 4'd0);

    // s stuck-at-1 on pattern 0
    fault = 2;
    pulse8();
    wait_done8(cyc);
    chk("sa1p0_sig", sig8, 8'hD8);
    chk("sa1p0_pass", pass8, 1'b0);
    chk("sa1p0_fail_cnt", fc8, CHK ? 5'd1 : 5'd0);
    chk("sa1p0_first_fail", ff8, 4'd0);

    // Reset during the 4th RUN cycle, with start also high
    fault = 0;
    pulse8();
    repeat (3) @(posedge clk);
    #1;
    chk("mid_stim", {x8, y8, c8}, 3'b011);
    @(negedge clk) begin rst_n = 1'b0; start8 = 1'b1; end
    @(posedge clk); #1;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_sig", sig8, 8'h00);
    chk("mid_rst_stim", {x8, y8, c8}, 3'b000);
    @(negedge clk) begin rst_n = 1'b1; start8 = 1'b0; end
    pulse8();
    wait_done8(cyc);
    chk("after_rst_sig", sig8, 8'hC5);

    // start held high through RUN into DONE
    @(negedge clk) start8 = 1'b1;
    @(posedge clk); #1;
    wait_done8(cyc);
    chk("held_run_len", cyc, 8);
    chk("held_done", done8, 1'b1);
    @(posedge clk); #1;
    chk("held_restart_busy", busy8, 1'b1);
    chk("held_restart_done", done8, 1'b0);
    chk("held_restart_sig", sig8, 8'h00);
    start8 = 1'b0;
    wait_done8(cyc);
    chk("held_rerun_len", cyc, 8);
    chk("held_rerun_sig", sig8, 8'hC5);

    // NPAT=16: stimulus wraps and the signature continues past C5
    model = 8'h00;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] p;
      p = 3'(i);
      model = misr_step(model, ^p, maj(p[2], p[1], p[0]));
    end
    @(negedge clk) start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("n16_busy", busy16, 1'b1);
      chk("n16_stim", {x16, y16, c16}, 32'(i % 8));
      @(posedge clk); #1;
    end
    chk("n16_done", done16, 1'b1);
    chk("n16_sig_model", sig16, model);
    chk("n16_sig_hand", sig16, 8'h99);
    chk("n16_pass", pass16, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
